pc_redirect_ctrl: RTL and testbench
===================================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the fetch address loaded by reset.
REQ-002 The block SHALL use a single clock `clk`, and `rst` SHALL be a synchronous, active-high reset.
REQ-003 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- redir_flag  in  1  next-PC redirect request from the EX-stage next-PC logic (jump, jalr or taken branch).
- redir_pc  in  32  redirect target.
- ex_valid  in  1  the EX-stage instruction is valid (not a bubble).
- load_use  in  1  load-use hazard detected this cycle.
- imem_gnt  in  1  instruction memory accepted imem_req this cycle; its response arrives next cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals the internal PC.
- fetch_drop  out  1  discard the instruction-memory response arriving this cycle.
- stall_if  out  1  hold the PC / IF stage.
- stall_id  out  1  hold the IF/ID register.
- flush_id  out  1  load a bubble into IF/ID.
- flush_ex  out  1  load a bubble into ID/EX.
- redir_cnt  out  16  saturating count of taken redirects.

Function
REQ-004 The block SHALL define redir_take = redir_flag & ex_valid; redir_flag with ex_valid=0 SHALL be ignored.
REQ-005 The state machine SHALL have three states: BOOT, RUN, DRAIN.
REQ-006 In BOOT: imem_req=0, flush_id=1, stall_if=1, other flush/stall outputs 0, PC held; next state RUN unconditionally; redir_take and load_use ignored.
REQ-007 In RUN and DRAIN, priority SHALL be redir_take > load_use > fetch-not-granted > normal.
REQ-008 redir_take: PC <= {redir_pc[31:1],1'b0}; flush_id=1, flush_ex=1, stall_if=0, stall_id=0; imem_req=1 at the old PC; next state DRAIN if imem_gnt=1 this cycle, else RUN.
REQ-009 load_use (no redir_take): imem_req=0; PC held; stall_if=1, stall_id=1, flush_ex=1, flush_id=0; next state RUN.
REQ-010 Fetch not granted (imem_req=1, imem_gnt=0, no redir_take, no load_use): PC held; stall_if=1, flush_id=1, stall_id=0, flush_ex=0.
REQ-011 Normal (imem_gnt=1, no redir_take, no load_use): PC <= PC + 32'd4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); all stall/flush outputs 0.
REQ-012 fetch_drop SHALL be 1 exactly in DRAIN, i.e. one cycle after a redirect cycle in which a wrong-path request was granted; DRAIN otherwise behaves as RUN, including issuing a request at the new PC.
REQ-013 A redir_take in DRAIN SHALL follow REQ-008: the next state is DRAIN again if imem_gnt=1, and fetch_drop stays 1 for that following cycle.
REQ-014 imem_gnt SHALL be ignored whenever imem_req=0.
REQ-015 redir_cnt SHALL increment by 1 on every redir_take cycle in RUN or DRAIN and saturate at 16'hFFFF.
REQ-016 All outputs except redir_cnt SHALL be combinational from state, PC and the inputs; PC, state and redir_cnt SHALL be registered.

Reset
REQ-017 With rst=1 at a clock edge, the block SHALL set PC=RESET_PC, state=BOOT and redir_cnt=0, overriding any simultaneous redirect or grant.
REQ-018 During and immediately after reset (BOOT), outputs SHALL be imem_req=0, fetch_drop=0, flush_id=1, stall_if=1, stall_id=0, flush_ex=0 and imem_addr=RESET_PC.
REQ-019 Reset asserted while in DRAIN SHALL cancel the pending drop: fetch_drop=0 in the cycle after reset.

Verification
REQ-020 Boot: release rst, hold imem_gnt=1 -> BOOT for one cycle with imem_req=0; imem_addr then sequences 0x0, 0x4, 0x8 on consecutive cycles.
REQ-021 Redirect with grant: at PC=0x100, redir_flag=1, ex_valid=1, redir_pc=0x2001, imem_gnt=1 -> flush_id=flush_ex=1 that cycle; next cycle imem_addr=0x2000, fetch_drop=1, redir_cnt=1.
REQ-022 Redirect without grant: same stimulus but imem_gnt=0 -> next cycle fetch_drop=0 and imem_addr=0x2000.
REQ-023 Priority: redir_take and load_use asserted in the same cycle -> redirect behaviour only, stall_id=0; load_use alone -> imem_req=0, stall_if=stall_id=flush_ex=1, PC unchanged.
REQ-024 Wrap and saturation: PC=0xFFFF_FFFC with grant -> next PC 0x0; redir_cnt preloaded to 0xFFFF by 65535 redirects, then one more redirect -> stays 0xFFFF.
REQ-025 Invalid EX stage: redir_flag=1 with ex_valid=0 -> no flush, PC advances by 4, redir_cnt unchanged.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer with redirect handling: steers the IF stage, flushes the
// wrong path and drops the one in-flight response fetched before a redirect.
module pc_redirect_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redir_flag,
   input  logic [31:0] redir_pc,
   input  logic        ex_valid,
   input  logic        load_use,
   input  logic        imem_gnt,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic        fetch_drop,
   output logic        stall_if,
   output logic        stall_id,
   output logic        flush_id,
   output logic        flush_ex,
   output logic [15:0] redir_cnt
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [15:0] cnt_q, cnt_d;
   logic        redir_take_s;

   assign redir_take_s = redir_flag & ex_valid;
   assign imem_addr    = pc_q;
   assign redir_cnt    = cnt_q;

   // State register, PC and redirect counter; reset overrides any same-cycle redirect or grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         cnt_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and pipeline control, priority redirect > load-use > no grant > advance.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      imem_req   = 1'b0;
      fetch_drop = 1'b0;
      stall_if   = 1'b0;
      stall_id   = 1'b0;
      flush_id   = 1'b0;
      flush_ex   = 1'b0;
      case (state_q)
         BOOT: begin
            flush_id = 1'b1;
            stall_if = 1'b1;
            state_d  = RUN;
         end
         RUN, DRAIN: begin
            fetch_drop = (state_q == DRAIN) ? 1'b1 : 1'b0;
            if (redir_take_s) begin
               // The old-PC request still goes out; if granted its response must be dropped.
               imem_req = 1'b1;
               flush_id = 1'b1;
               flush_ex = 1'b1;
               pc_d     = {redir_pc[31:1], 1'b0};
               if (imem_gnt) begin
                  state_d = DRAIN;
               end else begin
                  state_d = RUN;
               end
               if (cnt_q == 16'hFFFF) begin
                  cnt_d = cnt_q;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end else if (load_use) begin
               stall_if = 1'b1;
               stall_id = 1'b1;
               flush_ex = 1'b1;
               state_d  = RUN;
            end else begin
               imem_req = 1'b1;
               state_d  = RUN;
               if (imem_gnt) begin
                  pc_d = pc_q + 32'd4;
               end else begin
                  stall_if = 1'b1;
                  flush_id = 1'b1;
               end
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed plus random bench for pc_redirect_ctrl against a rule-level reference model.
module tb_pc_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst, redir_flag, ex_valid, load_use, imem_gnt;
   logic [31:0] redir_pc;
   logic        imem_req, fetch_drop, stall_if, stall_id, flush_id, flush_ex;
   logic [31:0] imem_addr;
   logic [15:0] redir_cnt;

   int errors = 0;
   int checks = 0;

   // reference model: booting flag, pending-drop flag, PC and redirect tally
   bit          m_boot;
   bit          m_drain;
   logic [31:0] m_pc;
   int          m_cnt;

   pc_redirect_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .redir_flag(redir_flag), .redir_pc(redir_pc),
      .ex_valid(ex_valid), .load_use(load_use), .imem_gnt(imem_gnt),
      .imem_req(imem_req), .imem_addr(imem_addr), .fetch_drop(fetch_drop),
      .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
      .flush_ex(flush_ex), .redir_cnt(redir_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock: drive at posedge+1, check at negedge, advance the model at posedge
   task automatic cyc(input bit r, input bit fl, input logic [31:0] rpc, input bit v,
                      input bit lu, input bit g, input bit do_chk);
      bit take;
      bit e_req, e_drop, e_sif, e_sid, e_fid, e_fex;
      rst = r; redir_flag = fl; redir_pc = rpc; ex_valid = v; load_use = lu; imem_gnt = g;
      #4;
      take = fl && v;
      e_req = 0; e_drop = 0; e_sif = 0; e_sid = 0; e_fid = 0; e_fex = 0;
      if (m_boot) begin
         e_fid = 1; e_sif = 1;
      end else begin
         e_drop = m_drain;
         if (take) begin
            e_req = 1; e_fid = 1; e_fex = 1;
         end else if (lu) begin
            e_sif = 1; e_sid = 1; e_fex = 1;
         end else begin
            e_req = 1;
            if (!g) begin e_sif = 1; e_fid = 1; end
         end
      end
      if (do_chk) begin
         chk("imem_req",   {31'd0, imem_req},   {31'd0, e_req});
         chk("imem_addr",  imem_addr,           m_pc);
         chk("fetch_drop", {31'd0, fetch_drop}, {31'd0, e_drop});
         chk("stall_if",   {31'd0, stall_if},   {31'd0, e_sif});
         chk("stall_id",   {31'd0, stall_id},   {31'd0, e_sid});
         chk("flush_id",   {31'd0, flush_id},   {31'd0, e_fid});
         chk("flush_ex",   {31'd0, flush_ex},   {31'd0, e_fex});
         chk("redir_cnt",  {16'd0, redir_cnt},  m_cnt);
      end
      @(posedge clk);
      if (r) begin
         m_pc = 32'h0000_0000; m_boot = 1; m_drain = 0; m_cnt = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (take) begin
         m_pc = rpc & 32'hFFFF_FFFE;
         m_drain = g;
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else begin
         m_drain = 0;
         if (!lu && g) m_pc = m_pc + 32'd4;
      end
      #1;
   endtask

   initial begin
      rst = 1; redir_flag = 0; redir_pc = 32'd0; ex_valid = 0; load_use = 0; imem_gnt = 0;
      m_pc = 32'd0; m_boot = 1; m_drain = 0; m_cnt = 0;
      @(posedge clk); #1;

      // reset and boot sequencing
      cyc(1, 0, 32'd0, 0, 0, 1, 0);
      cyc(1, 1, 32'h40, 1, 0, 1, 1);
      chk("boot_req", {31'd0, imem_req}, 32'd0);
      chk("boot_addr", imem_addr, 32'h0);
      cyc(0, 0, 32'd0, 0, 0, 1, 1);
      cyc(0, 0, 32'd0, 0, 0, 1, 1);
      chk("seq_4", imem_addr, 32'h4);
      cyc(0, 0, 32'd0, 0, 0, 1, 1);
      chk("seq_8", imem_addr, 32'h8);

      // redirect with grant from 0x100
      cyc(0, 1, 32'h100, 1, 0, 0, 1);
      chk("at_100", imem_addr, 32'h100);
      cyc(0, 1, 32'h2001, 1, 0, 1, 1);
      chk("drop_set", {31'd0, fetch_drop}, 32'd1);
      chk("redir_addr", imem_addr, 32'h2000);
      // redirect without grant
      cyc(0, 1, 32'h100, 1, 0, 0, 1);
      cyc(0, 1, 32'h2001, 1, 0, 0, 1);
      chk("nogrant_drop", {31'd0, fetch_drop}, 32'd0);
      chk("nogrant_addr", imem_addr, 32'h2000);

      // priority and load-use
      cyc(0, 1, 32'h300, 1, 1, 1, 1);
      chk("prio_addr", imem_addr, 32'h300);
      cyc(0, 0, 32'd0, 0, 1, 1, 1);
      cyc(0, 0, 32'd0, 0, 1, 0, 1);
      chk("lu_hold", imem_addr, 32'h300);

      // wrap and invalid-EX redirect
      cyc(0, 1, 32'hFFFF_FFFD, 1, 0, 0, 1);
      cyc(0, 0, 32'd0, 0, 0, 1, 1);
      chk("wrap", imem_addr, 32'h0);
      cyc(0, 1, 32'h5000, 0, 0, 1, 1);
      chk("inv_ex", imem_addr, 32'h4);

      // back-to-back redirects in DRAIN, then reset while draining
      cyc(0, 1, 32'h600, 1, 0, 1, 1);
      cyc(0, 1, 32'h700, 1, 0, 1, 1);
      chk("drain_again", {31'd0, fetch_drop}, 32'd1);
      cyc(1, 0, 32'd0, 0, 0, 1, 1);
      chk("rst_cancel", {31'd0, fetch_drop}, 32'd0);
      chk("rst_cnt", {16'd0, redir_cnt}, 32'd0);
      cyc(0, 0, 32'd0, 0, 0, 1, 1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
             ($urandom_range(0, 3) == 0), $urandom_range(0, 1), 1);
      end

      // counter saturation
      cyc(1, 0, 32'd0, 0, 0, 0, 1);
      cyc(0, 0, 32'd0, 0, 0, 0, 1);
      for (int i = 0; i < 65535; i++) begin
         cyc(0, 1, $urandom, 1, $urandom_range(0, 1), $urandom_range(0, 1), (i % 4096) == 0);
      end
      chk("cnt_full", {16'd0, redir_cnt}, 32'h0000_FFFF);
      cyc(0, 1, 32'h800, 1, 0, 1, 1);
      chk("cnt_sat", {16'd0, redir_cnt}, 32'h0000_FFFF);
      cyc(0, 0, 32'd0, 0, 0, 1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
